pll_reset_seq: RTL and testbench

Reset and lock sequencer for the capture-clock PLL. Runs on the free-running reference clock. Pulses the PLL reset, waits for lock with a timeout and bounded retries, and debounces LOCKED. Only then does it release the downstream reset for the derived clock domain. It re-sequences automatically on loss of lock and latches a fault after repeated lock failures.

---
 rtl/pll_reset_seq.sv | 157 +++++++++++++++
 tb/tb_pll_reset_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_seq
//  Description : Reset/lock sequencer for the capture-clock PLL. Pulses the
//                PLL reset, waits for lock with timeout and bounded retries,
//                debounces LOCKED and only then releases the downstream reset.
//                Re-sequences on loss of lock; latches FAULT after repeated
//                lock failures.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       restart_i,
    output logic       pll_rst_o,
    output logic       rst_out_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [3:0] retry_count_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       c_max_retries  = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             locked_meta_q, locked_s_q;
    logic             pll_rst_q, rst_out_q, ready_q, fault_q;

    // Two-flop synchroniser for the asynchronous LOCKED input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            locked_meta_q <= pll_locked_i;
            locked_s_q    <= locked_meta_q;
        end
    end

    // Next-state, counter and retry logic; restart overrides the state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (restart_i) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (cnt_q == c_rst_last) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock takes precedence over a coincident timeout
                    if (locked_s_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == c_timeout_last) begin
                        cnt_d = '0;
                        if (retry_q == c_max_retries) begin
                            state_d = FAULT;
                        end else begin
                            state_d = RESET_PLL;
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    // A dropout here is treated as a glitch: re-wait, no retry charged
                    if (!locked_s_q) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == c_stable_last) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!locked_s_q) begin
                        state_d = RESET_PLL;
                    end
                end
                FAULT: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // State register plus output flags decoded from the next state so that
    // every output is a flop aligned with the state it belongs to
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAULT);
            rst_out_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign pll_rst_o     = pll_rst_q;
    assign rst_out_o     = rst_out_q;
    assign ready_o       = ready_q;
    assign fault_o       = fault_q;
    assign retry_count_o = retry_q;
    assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reset_seq
//  Description : Self-checking bench for pll_reset_seq. Directed scenarios
//                followed by randomized LOCKED/restart/reset traffic, all
//                compared cycle by cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    localparam int P_RST  = 4;
    localparam int P_STB  = 8;
    localparam int P_TO   = 32;
    localparam int P_MAXR = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       pll_rst_o, rst_out_o, ready_o, fault_o;
    logic [3:0] retry_count_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0..4 with a cycle count and retry tally
    int m_ph = 0, m_cnt = 0, m_retry = 0, m_s1 = 0, m_s2 = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STB),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .MAX_RETRIES         (P_MAXR),
        .CNT_W               (16)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pll_locked_i  (pll_locked_i),
        .restart_i     (restart_i),
        .pll_rst_o     (pll_rst_o),
        .rst_out_o     (rst_out_o),
        .ready_o       (ready_o),
        .fault_o       (fault_o),
        .retry_count_o (retry_count_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected packed outputs {pll_rst, rst_out, ready, fault, retry[3:0], state[2:0]}
    function automatic int unsigned exp_vec();
        int unsigned v;
        int          r;
        r = (m_retry > P_MAXR) ? P_MAXR : m_retry;
        v = 0;
        if (m_ph == 0 || m_ph == 4) v = v | (1 << 10);
        if (m_ph != 3)              v = v | (1 << 9);
        if (m_ph == 3)              v = v | (1 << 8);
        if (m_ph == 4)              v = v | (1 << 7);
        v = v | (int'(r) << 3) | int'(m_ph);
        return v;
    endfunction

    function automatic int unsigned obs_vec();
        return int'({pll_rst_o, rst_out_o, ready_o, fault_o, retry_count_o, state_o});
    endfunction

    // Advance the model by one clock edge using the inputs presented to it
    task automatic model_edge();
        int ls;
        ls = m_s2;
        if (rst_i) begin
            m_s1 = 0; m_s2 = 0; m_ph = 0; m_cnt = 0; m_retry = 0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = int'(pll_locked_i);
        if (restart_i) begin
            m_ph = 0; m_cnt = 0; m_retry = 0;
            return;
        end
        case (m_ph)
            0: if (m_cnt == P_RST - 1) begin m_ph = 1; m_cnt = 0; end
               else m_cnt++;
            1: if (ls != 0) begin m_ph = 2; m_cnt = 0; end
               else if (m_cnt == P_TO - 1) begin
                   m_cnt = 0;
                   if (m_retry == P_MAXR) m_ph = 4;
                   else begin m_retry++; m_ph = 0; end
               end else m_cnt++;
            2: if (ls == 0) begin m_ph = 1; m_cnt = 0; end
               else if (m_cnt == P_STB - 1) begin m_ph = 3; m_cnt = 0; m_retry = 0; end
               else m_cnt++;
            3: begin m_cnt = 0; if (ls == 0) m_ph = 0; end
            default: m_cnt = 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("lockstep", obs_vec(), exp_vec());
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (pll_rst_o === 1'b1 && n < 200) begin n++; step(); end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (pll_rst_o === 1'b0 && n < 200) begin n++; step(); end
    endtask

    task automatic wait_ready(input int budget, output int ok);
        int k;
        k = 0;
        while (ready_o !== 1'b1 && k < budget) begin k++; step(); end
        ok = (ready_o === 1'b1) ? 1 : 0;
    endtask

    task automatic pulse_restart();
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
    endtask

    initial begin
        int n, ok, k, seen_wait, seen_pll, hold;

        // 1. Nominal bring-up
        rst_i = 1'b1; pll_locked_i = 1'b1;
        repeat (3) step();
        chk("reset_vec", obs_vec(), 32'h600);
        rst_i = 1'b0;
        count_high(n);
        chk("s1_pulse_len", n, P_RST);
        wait_ready(40, ok);
        chk("s1_ready", ok, 1);
        chk("s1_rst_out", rst_out_o, 0);
        chk("s1_retry", retry_count_o, 0);
        chk("s1_fault", fault_o, 0);

        // 2. One-cycle lock glitch while in STABLE
        pulse_restart();
        k = 0;
        while (!(m_ph == 2 && m_cnt == 4) && k < 50) begin k++; step(); end
        chk("s2_reach_stable", m_ph, 2);
        pll_locked_i = 1'b0;
        step();
        pll_locked_i = 1'b1;
        seen_wait = 0; seen_pll = 0; k = 0;
        while (ready_o !== 1'b1 && k < 30) begin
            k++; step();
            if (state_o == 3'd1) seen_wait = 1;
            if (pll_rst_o) seen_pll = 1;
        end
        chk("s2_back_to_wait", seen_wait, 1);
        chk("s2_no_pll_rst", seen_pll, 0);
        chk("s2_ready", ready_o, 1);
        chk("s2_retry", retry_count_o, 0);

        // 3. No lock: retries then FAULT
        pll_locked_i = 1'b0;
        pulse_restart();
        for (int p = 0; p < 3; p++) begin
            chk("s3_retry_step", retry_count_o, p);
            count_high(n);
            chk("s3_pulse_len", n, P_RST);
            count_low(n);
            chk("s3_wait_len", n, P_TO);
        end
        chk("s3_fault", fault_o, 1);
        chk("s3_state", state_o, 4);
        repeat (5) step();
        chk("s3_fault_sticky", {fault_o, pll_rst_o, rst_out_o}, 3'b111);
        chk("s3_retry_sat", retry_count_o, P_MAXR);

        // 4. Recovery from FAULT via restart
        pll_locked_i = 1'b1;
        pulse_restart();
        chk("s4_fault_clr", fault_o, 0);
        count_high(n);
        chk("s4_pulse_len", n, P_RST);
        wait_ready(40, ok);
        chk("s4_ready", ok, 1);
        chk("s4_retry", retry_count_o, 0);

        // 5. Loss of lock in RUN
        pll_locked_i = 1'b0;
        n = 0;
        while (rst_out_o !== 1'b1 && n < 10) begin n++; step(); end
        chk("s5_latency", n, 3);
        chk("s5_ready_low", ready_o, 0);
        pll_locked_i = 1'b1;
        count_high(n);
        chk("s5_pulse_len", n, P_RST);
        wait_ready(40, ok);
        chk("s5_ready", ok, 1);
        chk("s5_retry", retry_count_o, 0);

        // 6a. Lock arrives on the same edge as the timeout
        pll_locked_i = 1'b0;
        pulse_restart();
        k = 0;
        while (!(m_ph == 1 && m_cnt == P_TO - 3) && k < 60) begin k++; step(); end
        pll_locked_i = 1'b1;
        repeat (3) step();
        chk("s6_lock_wins", state_o, 2);
        chk("s6_no_retry", retry_count_o, 0);

        // 6b. rst and restart together
        rst_i = 1'b1; restart_i = 1'b1;
        step();
        chk("s6_reset_vec", obs_vec(), 32'h600);
        rst_i = 1'b0; restart_i = 1'b0;

        // Randomized traffic
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                pll_locked_i = ~pll_locked_i;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                   : $urandom_range(4, 60);
            end
            hold--;
            rst_i     = ($urandom_range(0, 399) == 0);
            restart_i = ($urandom_range(0, 149) == 0);
            step();
        end
        rst_i = 1'b0; restart_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
